// File: rtl/reboot_pkg.sv
// Shared types and constants for the reboot sequencer: FSM states, request
// cause encodings and the 32-bit counter width.
package reboot_pkg;

  localparam int CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    GRACE = 2'd2,
    FIRE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_BTN  = 2'd1,
    CAUSE_SW   = 2'd2,
    CAUSE_WDT  = 2'd3
  } cause_t;

  // Terminal value of a counter that must run for `cycles` cycles (cycles >= 1).
  function automatic cnt_t last_count(input int unsigned cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/reboot_sequencer_if.sv
// Request/status bundle between the board glue (master) and the reboot
// sequencer (slave).
interface reboot_sequencer_if;
  import reboot_pkg::*;

  logic   btn_n;
  logic   sw_req;
  logic   cancel;
  logic   wdt_kick;
  logic   do_reset;
  logic   pending;
  cause_t cause;
  logic   btn_level;

  modport master (
    output btn_n, sw_req, cancel, wdt_kick,
    input  do_reset, pending, cause, btn_level
  );

  modport slave (
    input  btn_n, sw_req, cancel, wdt_kick,
    output do_reset, pending, cause, btn_level
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce counter for the active-low user button;
// btn_level (1 = pressed) follows only a level that held for DEBOUNCE_CYCLES.
module btn_debounce
  import reboot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 48000
) (
  input  logic clk,
  input  logic nreset,
  input  logic btn_n,
  output logic btn_level
);

  localparam cnt_t DB_LAST = last_count(DEBOUNCE_CYCLES);

  logic sync_p0;
  logic sync_p1;
  logic pressed;
  cnt_t db_cnt;

  assign pressed = ~sync_p1;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
      // Any sample that agrees with the current level restarts the count.
      if (pressed == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_level <= pressed;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/reboot_sequencer.sv
// Arbitrates button / software / watchdog reboot requests and sequences one
// reboot through HOLD and GRACE into a sticky FIRE. Watchdog built only with REBOOT_WATCHDOG_EN.
module reboot_sequencer
  import reboot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 48000,
  parameter int unsigned HOLD_CYCLES     = 96000000,
  parameter int unsigned GRACE_CYCLES    = 4800000,
  parameter int unsigned WDT_CYCLES      = 480000000
) (
  input  logic                clk,
  input  logic                nreset,
  reboot_sequencer_if.slave   bus
);

  localparam cnt_t HOLD_LAST  = last_count(HOLD_CYCLES);
  localparam cnt_t GRACE_LAST = last_count(GRACE_CYCLES);

  state_t state;
  state_t state_nx;
  cnt_t   cnt;
  cnt_t   cnt_nx;
  cause_t cause_q;
  cause_t cause_nx;
  logic   pending_q;
  logic   do_reset_q;
  logic   btn_level;
  logic   btn_prev;
  logic   btn_rise;
  logic   wdt_expire;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk       (clk),
    .nreset    (nreset),
    .btn_n     (bus.btn_n),
    .btn_level (btn_level)
  );

  assign btn_rise = btn_level & ~btn_prev;

`ifdef REBOOT_WATCHDOG_EN
  localparam cnt_t WDT_LAST = last_count(WDT_CYCLES);

  logic wdt_armed;
  logic wdt_expired;
  cnt_t wdt_cnt;

  // A kick on the terminal cycle wins; after expiry the count parks until the next kick.
  assign wdt_expire = wdt_armed && !wdt_expired && !bus.wdt_kick && (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wdt_armed   <= 1'b0;
      wdt_expired <= 1'b0;
      wdt_cnt     <= '0;
    end else if (bus.wdt_kick) begin
      wdt_armed   <= 1'b1;
      wdt_expired <= 1'b0;
      wdt_cnt     <= '0;
    end else if (wdt_armed) begin
      if (wdt_expire) begin
        wdt_expired <= 1'b1;
      end else if (wdt_cnt != WDT_LAST) begin
        wdt_cnt <= wdt_cnt + cnt_t'(1);
      end
    end
  end
`else
  localparam int unsigned WDT_CYCLES_UNUSED = WDT_CYCLES;
  logic wdt_kick_unused;

  assign wdt_kick_unused = bus.wdt_kick;
  assign wdt_expire      = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + cnt_t'(1);
    cause_nx = cause_q;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (wdt_expire) begin
          state_nx = GRACE;
          cause_nx = CAUSE_WDT;
        end else if (bus.sw_req) begin
          state_nx = GRACE;
          cause_nx = CAUSE_SW;
        end else if (btn_rise) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (wdt_expire) begin
          state_nx = GRACE;
          cause_nx = CAUSE_WDT;
          cnt_nx   = '0;
        end else if (bus.sw_req) begin
          state_nx = GRACE;
          cause_nx = CAUSE_SW;
          cnt_nx   = '0;
        end else if (!btn_level) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nx = GRACE;
          cause_nx = CAUSE_BTN;
          cnt_nx   = '0;
        end
      end
      GRACE: begin
        // New requests are ignored here; only cancel or the grace timeout act.
        if (bus.cancel && (cause_q != CAUSE_WDT)) begin
          state_nx = IDLE;
          cause_nx = CAUSE_NONE;
          cnt_nx   = '0;
        end else if (cnt == GRACE_LAST) begin
          state_nx = FIRE;
          cnt_nx   = '0;
        end
      end
      FIRE: begin
        cnt_nx = cnt;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        cause_nx = CAUSE_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= IDLE;
      cnt        <= '0;
      cause_q    <= CAUSE_NONE;
      pending_q  <= 1'b0;
      do_reset_q <= 1'b0;
      btn_prev   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      cause_q    <= cause_nx;
      pending_q  <= (state_nx == GRACE);
      do_reset_q <= (state_nx == FIRE);
      btn_prev   <= btn_level;
    end
  end

  assign bus.do_reset  = do_reset_q;
  assign bus.pending   = pending_q;
  assign bus.cause     = cause_q;
  assign bus.btn_level = btn_level;

  a_fire_not_pending : assert property (@(posedge clk) disable iff (!nreset)
    !(do_reset_q && pending_q));

`ifndef REBOOT_WATCHDOG_EN
  a_no_wdt_cause : assert property (@(posedge clk) disable iff (!nreset)
    cause_q != CAUSE_WDT);
`endif

endmodule

// File: tb/tb_reboot_sequencer.sv
// Bench for reboot_sequencer: a per-cycle vector table for the software/cancel/reset
// paths plus hand-written button and watchdog sequences, all checked via a scoreboard.
module tb_reboot_sequencer;

  localparam int unsigned D = 4;
  localparam int unsigned H = 16;
  localparam int unsigned G = 8;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic nreset = 1'b0;

  reboot_sequencer_if bus();

  reboot_sequencer #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .GRACE_CYCLES    (G),
    .WDT_CYCLES      (W)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {do_reset, pending, cause[1:0], btn_level}.
  typedef struct {
    int          cyc;
    string       nm;
    logic [4:0]  exp;
  } sb_t;

  typedef struct {
    logic       nrst;
    logic       sw;
    logic       cn;
    logic       dr;
    logic       pd;
    logic [1:0] cs;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Output after edge N is compared against entries tagged with cycle N.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        sb_t        e;
        logic [4:0] got;
        e   = sb.pop_front();
        got = {bus.do_reset, bus.pending, bus.cause, bus.btn_level};
        checks = checks + 1;
        if (e.cyc != cyc || got !== e.exp) begin
          errors = errors + 1;
          $display("FAIL %s cyc %0d: dr/pd/cause/bl got %b required %b", e.nm, cyc, got, e.exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_next(input string nm, input logic dr, input logic pd,
                             input logic [1:0] cs, input logic bl);
    sb.push_back('{cyc: cyc + 1, nm: nm, exp: {dr, pd, cs, bl}});
  endtask

  function automatic void add(input logic nrst, input logic sw, input logic cn,
                              input logic dr, input logic pd, input logic [1:0] cs,
                              input int rep);
    for (int i = 0; i < rep; i++) tbl.push_back('{nrst, sw, cn, dr, pd, cs});
  endfunction

  task automatic reset_seq(input string nm);
    nreset       = 1'b0;
    bus.btn_n    = 1'b1;
    bus.sw_req   = 1'b0;
    bus.cancel   = 1'b0;
    bus.wdt_kick = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_next(nm, 1'b0, 1'b0, 2'd0, 1'b0);
      step();
    end
    nreset = 1'b1;
    expect_next(nm, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
  endtask

  initial begin
    bus.btn_n    = 1'b1;
    bus.sw_req   = 1'b0;
    bus.cancel   = 1'b0;
    bus.wdt_kick = 1'b0;

    // Columns: nreset, sw_req, cancel | do_reset, pending, cause, repeat.
    add(0, 0, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 1, 2, 1);
    add(1, 0, 0, 0, 1, 2, 3);
    add(1, 1, 0, 0, 1, 2, 1);
    add(1, 0, 0, 0, 1, 2, 3);
    add(1, 0, 0, 1, 0, 2, 2);
    add(1, 0, 1, 1, 0, 2, 1);
    add(1, 1, 0, 1, 0, 2, 1);
    add(1, 0, 0, 1, 0, 2, 2);
    // reset while in FIRE
    add(0, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 2);
    // cancel during GRACE with software cause
    add(1, 1, 0, 0, 1, 2, 1);
    add(1, 0, 0, 0, 1, 2, 3);
    add(1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 10);
    // cancel coincident with the grace terminal count
    add(1, 1, 0, 0, 1, 2, 1);
    add(1, 0, 0, 0, 1, 2, 7);
    add(1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 4);
    // reset during GRACE, then a clean software reboot
    add(1, 1, 0, 0, 1, 2, 1);
    add(1, 0, 0, 0, 1, 2, 2);
    add(0, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 1, 2, 1);
    add(1, 0, 0, 0, 1, 2, 7);
    add(1, 0, 0, 1, 0, 2, 3);
    add(0, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      nreset     = tbl[i].nrst;
      bus.sw_req = tbl[i].sw;
      bus.cancel = tbl[i].cn;
      expect_next($sformatf("vec%0d", i), tbl[i].dr, tbl[i].pd, tbl[i].cs, 1'b0);
      step();
    end
    bus.sw_req = 1'b0;
    bus.cancel = 1'b0;

    // 3-cycle glitches never reach the debounced level.
    for (int k = 1; k <= 20; k++) begin
      bus.btn_n = !((k >= 1 && k <= 3) || (k >= 9 && k <= 11));
      expect_next("glitch", 1'b0, 1'b0, 2'd0, 1'b0);
      step();
    end

    // 12-cycle press: level pulses, HOLD never completes.
    for (int k = 1; k <= 30; k++) begin
      bus.btn_n = !(k <= 12);
      expect_next("short_press", 1'b0, 1'b0, 2'd0, (k >= 6 && k <= 17));
      step();
    end

    // Long press: level at 6, pending 23..30, do_reset from 31.
    for (int k = 1; k <= 40; k++) begin
      bus.btn_n = 1'b0;
      expect_next("long_press", (k >= 31), (k >= 23 && k <= 30),
                  (k >= 23) ? 2'd1 : 2'd0, (k >= 6));
      step();
    end
    reset_seq("rst_after_btn");

`ifdef REBOOT_WATCHDOG_EN
    // One kick then silence; sw_req and cancel in GRACE are ignored.
    for (int k = 1; k <= 45; k++) begin
      bus.wdt_kick = (k == 1);
      bus.sw_req   = (k == 35);
      bus.cancel   = (k == 36);
      expect_next("wdt_expire", (k >= 41), (k >= 33 && k <= 40),
                  (k >= 33) ? 2'd3 : 2'd0, 1'b0);
      step();
    end
    reset_seq("rst_after_wdt");

    // Expiry coincident with sw_req: watchdog wins.
    for (int k = 1; k <= 42; k++) begin
      bus.wdt_kick = (k == 1);
      bus.sw_req   = (k == 33);
      expect_next("wdt_vs_sw", (k >= 41), (k >= 33 && k <= 40),
                  (k >= 33) ? 2'd3 : 2'd0, 1'b0);
      step();
    end
    reset_seq("rst_after_wdt_sw");

    // Regular kicks, one landing exactly on the terminal count, then silence.
    for (int k = 1; k <= 125; k++) begin
      bus.wdt_kick = (k == 1 || k == 21 || k == 41 || k == 61 || k == 93);
      expect_next("wdt_kicked", 1'b0, (k >= 125), (k >= 125) ? 2'd3 : 2'd0, 1'b0);
      step();
    end
    reset_seq("rst_after_kicks");

    // Reset disarms the watchdog.
    for (int k = 1; k <= 60; k++) begin
      expect_next("wdt_unarmed", 1'b0, 1'b0, 2'd0, 1'b0);
      step();
    end
`else
    for (int k = 1; k <= 60; k++) begin
      bus.wdt_kick = (k == 1);
      expect_next("wdt_absent", 1'b0, 1'b0, 2'd0, 1'b0);
      step();
    end
`endif

    for (int i = 0; i < 5 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
